// File: rtl/lifting_step_unit.sv
// lifting_step_unit: one predict+update lifting pair on a stream of {odd, even} pairs.
// Define LIFTING_RUNTIME_COEF_EN to take coefficients from ports, captured per line.
module lifting_step_unit #(
    parameter int  DataWidth = 16,
    parameter int  Point     = 10,
    parameter int  Lanes     = 1,
    parameter real CoefA     = -1.586134342059924,
    parameter real CoefB     = -0.052980118572961
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
`ifdef LIFTING_RUNTIME_COEF_EN
    input  logic signed [DataWidth-1:0]    coef_a_i,
    input  logic signed [DataWidth-1:0]    coef_b_i,
`endif
    output logic                           s_ready_o,
    input  logic                           s_valid_i,
    input  logic                           s_sof_i,
    input  logic                           s_eol_i,
    input  logic [Lanes*2*DataWidth-1:0]   s_data_i,
    input  logic                           m_ready_i,
    output logic                           m_valid_o,
    output logic                           m_sof_o,
    output logic                           m_eol_o,
    output logic [Lanes*2*DataWidth-1:0]   m_data_o,
    output logic                           drop_o
);
    localparam int W  = DataWidth;
    localparam int BW = 2 * W;
    localparam int PW = 2 * W + 2;

    localparam logic signed [PW-1:0] Half   = PW'(1) << (Point - 1);
    localparam logic signed [PW-1:0] SatMax =
        {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SatMin =
        {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_e;

    state_e                   state;
    logic                     first;
    logic                     accept;
    logic                     out_free;
    logic signed [W-1:0]      coef_a;
    logic signed [W-1:0]      coef_b;
    logic [Lanes-1:0][W-1:0]  in_e;
    logic [Lanes-1:0][W-1:0]  in_o;
    logic [Lanes-1:0][W-1:0]  held_e;
    logic [Lanes-1:0][W-1:0]  held_o;
    logic [Lanes-1:0][W-1:0]  prev_y;
    logic [Lanes-1:0][W-1:0]  y_odd;
    logic [Lanes-1:0][W-1:0]  y_even;
    logic [Lanes*BW-1:0]      out_data;

    function automatic logic signed [W:0] ext(
        input logic signed [W-1:0] v
    );
        return {v[W-1], v};
    endfunction

    // x + round(s*c / 2**Point), saturated to the sample range
    function automatic logic signed [W-1:0] lift(
        input logic signed [W-1:0] x,
        input logic signed [W:0]   s,
        input logic signed [W-1:0] c
    );
        logic signed [PW-1:0] acc;
        logic signed [PW-1:0] s_x;
        logic signed [PW-1:0] c_x;
        logic signed [PW-1:0] x_x;
        s_x = {{(PW-W-1){s[W]}}, s};
        c_x = {{(PW-W){c[W-1]}}, c};
        x_x = {{(PW-W){x[W-1]}}, x};
        acc = (s_x * c_x + Half) >>> Point;
        acc = acc + x_x;
        if (acc > SatMax) begin
            acc = SatMax;
        end else if (acc < SatMin) begin
            acc = SatMin;
        end
        return acc[W-1:0];
    endfunction

    assign out_free  = ~m_valid_o | m_ready_i;
    assign s_ready_o = (state != FLUSH) & out_free;
    assign accept    = s_valid_i & s_ready_o;

`ifdef LIFTING_RUNTIME_COEF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            coef_a <= '0;
            coef_b <= '0;
        end else if (accept && s_sof_i) begin
            coef_a <= coef_a_i;
            coef_b <= coef_b_i;
        end
    end
`else
    localparam logic signed [W-1:0] QuantA =
        W'($rtoi(CoefA * (2.0 ** Point)));
    localparam logic signed [W-1:0] QuantB =
        W'($rtoi(CoefB * (2.0 ** Point)));
    assign coef_a = QuantA;
    assign coef_b = QuantB;
`endif

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        logic signed [W-1:0] e_h;
        logic signed [W-1:0] o_h;
        logic signed [W-1:0] e_r;
        logic signed [W-1:0] y_o;
        logic signed [W-1:0] y_p;
        logic signed [W:0]   s_o;
        logic signed [W:0]   s_e;
        assign in_e[k] = s_data_i[k*BW +: W];
        assign in_o[k] = s_data_i[k*BW+W +: W];
        assign e_h = held_e[k];
        assign o_h = held_o[k];
        // mirror the even sample at line end
        assign e_r = (state == FLUSH) ? e_h : in_e[k];
        assign s_o = ext(e_h) + ext(e_r);
        assign y_o = lift(o_h, s_o, coef_a);
        // mirror the odd result at line start
        assign y_p = first ? y_o : prev_y[k];
        assign s_e = ext(y_p) + ext(y_o);
        assign y_odd[k]  = y_o;
        assign y_even[k] = lift(e_h, s_e, coef_b);
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < Lanes; k++) begin
            out_data[k*BW +: W]   = y_even[k];
            out_data[k*BW+W +: W] = y_odd[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            first     <= 1'b0;
            held_e    <= '0;
            held_o    <= '0;
            prev_y    <= '0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= '0;
            drop_o    <= 1'b0;
        end else begin
            drop_o <= 1'b0;
            if (m_ready_i) m_valid_o <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    held_e <= in_e;
                    held_o <= in_o;
                    first  <= 1'b1;
                    state  <= s_eol_i ? FLUSH : HOLD;
                end
                HOLD: if (accept) begin
                    held_e <= in_e;
                    held_o <= in_o;
                    state  <= s_eol_i ? FLUSH : HOLD;
                    if (s_sof_i) begin
                        drop_o <= 1'b1;
                        first  <= 1'b1;
                    end else begin
                        m_valid_o <= 1'b1;
                        m_sof_o   <= first;
                        m_eol_o   <= 1'b0;
                        m_data_o  <= out_data;
                        prev_y    <= y_odd;
                        first     <= 1'b0;
                    end
                end
                FLUSH: if (out_free) begin
                    m_valid_o <= 1'b1;
                    m_sof_o   <= first;
                    m_eol_o   <= 1'b1;
                    m_data_o  <= out_data;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lifting_step_unit.sv
// tb_lifting_step_unit: directed and random lines checked against an
// arithmetic model of the lifting equations with symmetric extension.
module tb_lifting_step_unit;
    localparam int PT = 10;
    localparam int CA = 512;
    localparam int CB = 256;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        s_ready_o;
    logic        s_valid_i = 1'b0;
    logic        s_sof_i = 1'b0;
    logic        s_eol_i = 1'b0;
    logic [63:0] s_data_i = '0;
    logic        m_ready_i = 1'b1;
    logic        m_valid_o;
    logic        m_sof_o;
    logic        m_eol_o;
    logic [63:0] m_data_o;
    logic        drop_o;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int stall_bad = 0;
    int drop_cnt = 0;

    int ve[2][64];
    int vo[2][64];
    logic [65:0] exp_q[$];
    logic [65:0] got_q[$];

    always #5 clk_i = ~clk_i;

    lifting_step_unit #(
        .DataWidth(16), .Point(PT), .Lanes(2),
        .CoefA(0.5), .CoefB(0.25)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef LIFTING_RUNTIME_COEF_EN
        .coef_a_i(16'sd512), .coef_b_i(16'sd256),
`endif
        .s_ready_o(s_ready_o), .s_valid_i(s_valid_i),
        .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_data_i(s_data_i),
        .m_ready_i(m_ready_i), .m_valid_o(m_valid_o),
        .m_sof_o(m_sof_o), .m_eol_o(m_eol_o), .m_data_o(m_data_o),
        .drop_o(drop_o)
    );

    // reference model
    function automatic int rm(int s, int c);
        longint p;
        p = longint'(s) * longint'(c) + longint'(1 << (PT - 1));
        return int'(p >>> PT);
    endfunction

    function automatic int sat(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int yodd(int l, int s, int n, int k);
        int nx;
        nx = (k == n - 1) ? ve[l][s+k] : ve[l][s+k+1];
        return sat(vo[l][s+k] + rm(ve[l][s+k] + nx, CA));
    endfunction

    function automatic void model_line(int s, int n);
        for (int k = 0; k < n; k++) begin
            logic [65:0] w;
            int yo, yp, ye;
            w = '0;
            for (int l = 0; l < 2; l++) begin
                yo = yodd(l, s, n, k);
                yp = yodd(l, s, n, (k == 0) ? 0 : k - 1);
                ye = sat(ve[l][s+k] + rm(yp + yo, CB));
                w[l*32 +: 16]    = 16'(ye);
                w[l*32+16 +: 16] = 16'(yo);
            end
            w[65] = (k == 0);
            w[64] = (k == n - 1);
            exp_q.push_back(w);
        end
    endfunction

    function automatic logic [63:0] pair_data(int i);
        logic [63:0] d;
        for (int l = 0; l < 2; l++) begin
            d[l*32 +: 16]    = 16'(ve[l][i]);
            d[l*32+16 +: 16] = 16'(vo[l][i]);
        end
        return d;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // output monitor: records transfers, stalls and drop pulses
    initial begin
        logic        prev_stall;
        logic [65:0] prev_word;
        logic [65:0] cur;
        prev_stall = 1'b0;
        prev_word = '0;
        forever begin
            @(negedge clk_i);
            cur = {m_sof_o, m_eol_o, m_data_o};
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!m_valid_o || cur != prev_word))
                    stall_bad++;
                if (m_valid_o && m_ready_i) got_q.push_back(cur);
                if (drop_o) drop_cnt++;
                prev_stall = m_valid_o && !m_ready_i;
                prev_word = cur;
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk_i);
            #1;
            case (ready_mode)
                1: begin
                    m_ready_i = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                end
                2: m_ready_i = ($urandom_range(0, 2) != 0);
                3: m_ready_i = 1'b0;
                default: m_ready_i = 1'b1;
            endcase
        end
    end

    task automatic drive_beat(input logic [63:0] d, input bit sof,
                              input bit eol);
        int t;
        t = 0;
        s_valid_i = 1'b1;
        s_data_i = d;
        s_sof_i = sof;
        s_eol_i = eol;
        @(negedge clk_i);
        while (!s_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!s_ready_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: s_ready_o=%b after %0d cycles, required 1",
                     s_ready_o, t);
        end
        @(posedge clk_i);
        #1;
        s_valid_i = 1'b0;
        s_sof_i = 1'b0;
        s_eol_i = 1'b0;
    endtask

    task automatic send_line(input int s, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            drive_beat(pair_data(s + k), k == 0, k == n - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk_i);
                #1;
            end
        end
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 200) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL output_timeout: got %0d beats, required %0d",
                     got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checks++;
        if ({m_valid_o, m_sof_o, m_eol_o, drop_o, s_ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: valid/sof/eol/drop/ready=%b required 00001",
                     {m_valid_o, m_sof_o, m_eol_o, drop_o, s_ready_o});
        end
        checks++;
        if (m_data_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", m_data_o);
        end
    endtask

    task automatic load_basic();
        ve[0][0] = 100; vo[0][0] = 10;
        ve[0][1] = 200; vo[0][1] = 20;
        for (int i = 0; i < 2; i++) begin
            ve[1][i] = rnd16() / 4;
            vo[1][i] = rnd16() / 4;
        end
    endtask

    task automatic test_line();
        ready_mode = 0;
        got_q.delete();
        exp_q.delete();
        load_basic();
        model_line(0, 2);
        drive_beat(pair_data(0), 1, 0);
        drive_beat(pair_data(1), 0, 1);
        checks++;
        if (s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: s_ready_o=%b required 0", s_ready_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL after_flush_ready: s_ready_o=%b required 1", s_ready_o);
        end
        wait_out(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL line beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() >= 2) begin
            checks++;
            if ({got_q[0][65], got_q[0][31:0], got_q[1][64], got_q[1][31:0]}
                !== {1'b1, 16'd160, 16'd180, 1'b1, 16'd220, 16'd295}) begin
                errors++;
                $display("FAIL line_lane0: got %h/%h required sof 160/180, eol 220/295",
                         got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_single_pair();
        ready_mode = 0;
        got_q.delete();
        exp_q.delete();
        ve[0][0] = 64; vo[0][0] = 0;
        ve[1][0] = rnd16() / 4; vo[1][0] = rnd16() / 4;
        model_line(0, 1);
        drive_beat(pair_data(0), 1, 1);
        wait_out(1);
        checks++;
        if (got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL single: got %h required %h", got_q[0], exp_q[0]);
        end
        checks++;
        if ({got_q[0][65:64], got_q[0][31:0]} !== {2'b11, 16'd64, 16'd96}) begin
            errors++;
            $display("FAIL single_lane0: got %h required sof,eol 64/96", got_q[0]);
        end
    endtask

    task automatic test_saturation();
        ready_mode = 0;
        got_q.delete();
        exp_q.delete();
        ve[0][0] = 30000; vo[0][0] = 30000;
        ve[0][1] = 30000; vo[0][1] = 0;
        for (int i = 0; i < 2; i++) begin
            ve[1][i] = -ve[0][i];
            vo[1][i] = -vo[0][i];
        end
        model_line(0, 2);
        send_line(0, 2, 0);
        wait_out(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sat beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({got_q[0][31:16], got_q[0][63:48]} !== {16'h7fff, 16'h8000}) begin
            errors++;
            $display("FAIL sat_yodd0: got %h/%h required 7fff/8000",
                     got_q[0][31:16], got_q[0][63:48]);
        end
    endtask

    task automatic test_rounding();
        ready_mode = 0;
        got_q.delete();
        exp_q.delete();
        ve[0][0] = 1; vo[0][0] = 0;
        ve[0][1] = 2; vo[0][1] = 0;
        ve[1][0] = -1; vo[1][0] = 0;
        ve[1][1] = -2; vo[1][1] = 0;
        model_line(0, 2);
        send_line(0, 2, 0);
        wait_out(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL round beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if ({got_q[0][31:16], got_q[0][63:48]} !== {16'd2, 16'hffff}) begin
            errors++;
            $display("FAIL round_half: got %h/%h required 0002/ffff",
                     got_q[0][31:16], got_q[0][63:48]);
        end
    endtask

    task automatic test_backpressure();
        got_q.delete();
        exp_q.delete();
        stall_bad = 0;
        ready_mode = 1;
        load_basic();
        model_line(0, 2);
        send_line(0, 2, 0);
        wait_out(2);
        repeat (6) @(posedge clk_i);
        #1;
        ready_mode = 0;
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL bp_count: got %0d beats required 2", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d changes while stalled, required 0", stall_bad);
        end
    endtask

    task automatic test_lanes_drop_reset();
        logic signed [15:0] a;
        ready_mode = 0;
        repeat (2) @(posedge clk_i);
        #1;
        got_q.delete();
        exp_q.delete();
        drop_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            ve[0][i] = 8 * $urandom_range(0, 400) - 1600;
            vo[0][i] = 8 * $urandom_range(0, 400) - 1600;
            ve[1][i] = -ve[0][i];
            vo[1][i] = -vo[0][i];
        end
        model_line(0, 2);
        void'(exp_q.pop_back());
        model_line(2, 3);
        drive_beat(pair_data(0), 1, 0);
        drive_beat(pair_data(1), 0, 0);
        drive_beat(pair_data(2), 1, 0);
        drive_beat(pair_data(3), 0, 0);
        drive_beat(pair_data(4), 0, 1);
        wait_out(4);
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL drop_count_beats: got %0d required 4", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL drop beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
            for (int h = 0; h < 2; h++) begin
                a = got_q[i][h*16 +: 16];
                checks++;
                if (got_q[i][32+h*16 +: 16] !== 16'(-a)) begin
                    errors++;
                    $display("FAIL lane_neg beat%0d: lane1 %h required %h",
                             i, got_q[i][32+h*16 +: 16], 16'(-a));
                end
            end
        end
        checks++;
        if (drop_cnt != 1) begin
            errors++;
            $display("FAIL drop_pulse: got %0d pulses required 1", drop_cnt);
        end
        ready_mode = 3;
        repeat (2) @(posedge clk_i);
        #1;
        got_q.delete();
        drive_beat(pair_data(5), 1, 0);
        drive_beat(pair_data(6), 0, 0);
        checks++;
        if (m_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL midline_valid: m_valid_o=%b required 1", m_valid_o);
        end
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        checks++;
        if (m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL midline_reset: m_valid_o=%b required 0", m_valid_o);
        end
        ready_mode = 0;
        repeat (6) @(posedge clk_i);
        #1;
        checks++;
        if (got_q.size() != 0 || s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: %0d beats, s_ready_o=%b required 0 beats, 1",
                     got_q.size(), s_ready_o);
        end
    endtask

    task automatic test_random_lines();
        int n;
        ready_mode = 2;
        for (int ln = 0; ln < 25; ln++) begin
            got_q.delete();
            exp_q.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                for (int l = 0; l < 2; l++) begin
                    ve[l][i] = (ln % 2 == 0) ? rnd16() : rnd16() / 16;
                    vo[l][i] = (ln % 2 == 0) ? rnd16() : rnd16() / 16;
                end
            end
            model_line(0, n);
            send_line(0, n, 1);
            wait_out(n);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand line%0d beat%0d: got %h required %h",
                             ln, i, got_q[i], exp_q[i]);
                end
            end
        end
        ready_mode = 0;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_single_pair();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_lanes_drop_reset();
        test_random_lines();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
